// File: rtl/adc_uart_tx_pkg.sv
// Shared definitions for the ADC sample UART transmitter: packet layout,
// FSM encodings and the byte/checksum helpers.
package adc_uart_tx_pkg;

  localparam int          PACKET_BYTES = 7;
  localparam int          LAST_BYTE    = PACKET_BYTES - 1;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  typedef enum logic {
    PKT_IDLE,
    PKT_SEND
  } pkt_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

  // XOR of the five payload bytes; the sync byte is deliberately excluded.
  function automatic logic [7:0] word_csum(input logic [39:0] w);
    return w[39:32] ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  function automatic logic [7:0] packet_byte(input logic [7:0]  sync,
                                             input logic [39:0] w,
                                             input logic [7:0]  csum,
                                             input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = w[39:32];
      3'd2:    b = w[31:24];
      3'd3:    b = w[23:16];
      3'd4:    b = w[15:8];
      3'd5:    b = w[7:0];
      default: b = csum;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_uart_tx_if.sv
// Sample-set handshake between the SPI capture side and the packet transmitter.
// A set transfers on a clk edge where sample_valid && sample_ready; valid while
// !ready is not queued, it is reported on dropped in the following cycle.
interface adc_uart_tx_if;
  logic       sample_valid;
  logic [9:0] ch1;
  logic [9:0] ch2;
  logic [9:0] ch3;
  logic [9:0] ch4;
  logic       sample_ready;
  logic       dropped;

  modport master (
    output sample_valid, ch1, ch2, ch3, ch4,
    input  sample_ready, dropped
  );

  modport slave (
    input  sample_valid, ch1, ch2, ch3, ch4,
    output sample_ready, dropped
  );
endinterface

// File: rtl/adc_uart_tx_byte.sv
// 8N1 byte serializer with a load/done handshake. done pulses in the last
// cycle of the stop bit so a load in that same cycle chains bytes with no gap.
module uart_tx_byte
  import adc_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [7:0] data,
  input  logic       load,
  output logic       done,
  output logic       tx,
  output ser_state_e dbg_state
);

  localparam int             TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  TMAX = TW'(CLKS_PER_BIT - 1);

  ser_state_e    state;
  ser_state_e    state_next;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;
  logic          take;
  logic          tx_next;

  assign bit_end   = (timer == TMAX);
  assign take      = load && ((state == SER_IDLE) || done);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= SER_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      if ((state == SER_IDLE) || bit_end) timer <= '0;
      else                                timer <= timer + TW'(1);
      if (take) begin
        shift   <= data;
        bit_idx <= '0;
      end else if ((state == SER_DATA) && bit_end) begin
        shift   <= {1'b0, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SER_IDLE:  if (load) state_next = SER_START;
      SER_START: if (bit_end) state_next = SER_DATA;
      SER_DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = SER_STOP;
      SER_STOP:  if (bit_end) state_next = load ? SER_START : SER_IDLE;
      default:   state_next = SER_IDLE;
    endcase
  end

  // tx is registered, so it is derived from the state being entered.
  always_comb begin
    done    = (state == SER_STOP) && bit_end;
    tx_next = 1'b1;
    case (state_next)
      SER_START: tx_next = 1'b0;
      SER_DATA:  tx_next = ((state == SER_DATA) && bit_end) ? shift[1] : shift[0];
      default:   tx_next = 1'b1;
    endcase
  end

endmodule

// File: rtl/adc_uart_tx.sv
// Frames one 4x10-bit ADC sample set as SYNC, five payload bytes and an XOR
// checksum, and streams the seven bytes back-to-back on tx as 8N1 UART.
module adc_uart_tx
  import adc_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_b,
  adc_uart_tx_if.slave s_if,
  output logic         busy,
  output logic         tx,
  output pkt_state_e   dbg_state,
  output ser_state_e   dbg_ser_state
);

  pkt_state_e  state;
  pkt_state_e  state_next;
  logic [39:0] hold;
  logic [7:0]  csum;
  logic [2:0]  byte_idx;
  logic        dropped_q;
  logic [39:0] in_word;
  logic        ready_c;
  logic        accept;
  logic        last_byte;
  logic        ser_load;
  logic        ser_done;
  logic [7:0]  ser_data;

  assign in_word          = {s_if.ch1, s_if.ch2, s_if.ch3, s_if.ch4};
  assign last_byte        = (byte_idx == 3'(LAST_BYTE));
  assign s_if.sample_ready = ready_c;
  assign s_if.dropped      = dropped_q;
  assign dbg_state        = state;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= PKT_IDLE;
      hold      <= '0;
      csum      <= '0;
      byte_idx  <= '0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_next;
      dropped_q <= s_if.sample_valid && !ready_c;
      if (accept) begin
        hold     <= in_word;
        csum     <= word_csum(in_word);
        byte_idx <= '0;
      end else if ((state == PKT_SEND) && ser_done) begin
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      PKT_IDLE: if (accept) state_next = PKT_SEND;
      PKT_SEND: if (ser_done && last_byte) state_next = PKT_IDLE;
      default:  state_next = PKT_IDLE;
    endcase
  end

  // The sync byte is loaded on the accepting edge itself (the holding register
  // is not yet valid then); later bytes come from the latched word.
  always_comb begin
    ready_c  = (state == PKT_IDLE);
    busy     = (state == PKT_SEND);
    accept   = s_if.sample_valid && ready_c;
    ser_load = accept || ((state == PKT_SEND) && ser_done && !last_byte);
    ser_data = accept ? SYNC_BYTE
                      : packet_byte(SYNC_BYTE, hold, csum, byte_idx + 3'd1);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .reset_b   (reset_b),
    .data      (ser_data),
    .load      (ser_load),
    .done      (ser_done),
    .tx        (tx),
    .dbg_state (dbg_ser_state)
  );

endmodule

// File: tb/tb_adc_uart_tx.sv
// Self-checking bench for adc_uart_tx: a cycle model of ready/busy/dropped
// and a UART receiver that checks decoded bytes against a scoreboard queue.
module tb_adc_uart_tx;
  import adc_uart_tx_pkg::*;

  localparam int CPB     = 4;
  localparam int PKT_CYC = 70 * CPB;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       busy;
  logic       tx;
  pkt_state_e dbg_state;
  ser_state_e dbg_ser_state;

  adc_uart_tx_if u_if ();

  adc_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .s_if          (u_if.slave),
    .busy          (busy),
    .tx            (tx),
    .dbg_state     (dbg_state),
    .dbg_ser_state (dbg_ser_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int ready_from = 0;
  logic exp_drop = 1'b0;
  logic prev_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_packet(input logic [9:0] a, b, c, d);
    logic [39:0] w;
    logic [7:0]  cs;
    logic [7:0]  by;
    w  = {a, b, c, d};
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 5; k++) begin
      by = w[39 - 8*k -: 8];
      cs = cs ^ by;
      exp_q.push_back(by);
    end
    exp_q.push_back(cs);
  endtask

  // driver: called just after a negedge; checks this cycle, drives the next
  task automatic drive_cycle(input logic v, input logic [9:0] a, b, c, d);
    logic rdy;
    rdy = (cyc >= ready_from);
    check("sample_ready", u_if.sample_ready, rdy);
    check("busy", busy, !rdy);
    check("dropped", u_if.dropped, exp_drop);
    if (prev_acc)  check("tx_start", tx, 1'b0);
    else if (rdy)  check("tx_idle", tx, 1'b1);
    u_if.sample_valid = v;
    u_if.ch1 = a;
    u_if.ch2 = b;
    u_if.ch3 = c;
    u_if.ch4 = d;
    prev_acc = v && rdy;
    if (prev_acc) begin
      push_packet(a, b, c, d);
      ready_from = cyc + 1 + PKT_CYC;
    end
    exp_drop = v && !rdy;
    @(negedge clk);
  endtask

  function automatic logic [9:0] rnd10();
    return 10'($urandom_range(0, 1023));
  endfunction

  // inputs keep changing while the packet is in flight
  task automatic idle_until_ready();
    int k;
    k = 0;
    while ((cyc < ready_from) && (k < 2000)) begin
      drive_cycle(1'b0, rnd10(), rnd10(), rnd10(), rnd10());
      k++;
    end
  endtask

  task automatic apply_reset(input int hold_cycles);
    #2 reset_b = 1'b0;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", u_if.sample_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_dropped", u_if.dropped, 1'b0);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check("rst_tx_hold", tx, 1'b1);
    end
    #2 reset_b = 1'b1;
    @(negedge clk);
    exp_q.delete();
    ready_from = cyc;
    exp_drop   = 1'b0;
    prev_acc   = 1'b0;
  endtask

  // UART receiver: samples mid-bit, abandons a byte if reset hits
  task automatic rx_byte();
    logic [7:0] b;
    logic [7:0] e;
    repeat (2) @(negedge clk);
    if (reset_b !== 1'b1) return;
    check("rx_start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      if (reset_b !== 1'b1) return;
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (reset_b !== 1'b1) return;
    check("rx_stop_bit", tx, 1'b1);
    check("rx_expected_byte", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rx_byte", b, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if ((reset_b === 1'b1) && (tx === 1'b0)) rx_byte();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    u_if.sample_valid = 1'b0;
    u_if.ch1 = '0;
    u_if.ch2 = '0;
    u_if.ch3 = '0;
    u_if.ch4 = '0;
    @(negedge clk);
    apply_reset(3);

    // idle after reset
    for (int i = 0; i < 50; i++) drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);

    // reference packet A5 FF C0 05 56 AA C6
    drive_cycle(1'b1, 10'h3FF, 10'h000, 10'h155, 10'h2AA);
    idle_until_ready();
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);

    // all-zero packet
    drive_cycle(1'b1, 10'h000, 10'h000, 10'h000, 10'h000);
    idle_until_ready();
    drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);

    // random single samples with inputs churning during SEND
    for (int p = 0; p < 2; p++) begin
      drive_cycle(1'b1, rnd10(), rnd10(), rnd10(), rnd10());
      idle_until_ready();
      repeat ($urandom_range(0, 3)) drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);
    end

    // valid held continuously: back-to-back packets, dropped elsewhere
    for (int i = 0; i < 1000; i++) drive_cycle(1'b1, rnd10(), rnd10(), rnd10(), rnd10());
    idle_until_ready();
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);
    check("queue_drained_pre_reset", exp_q.size(), 0);

    // reset in the middle of byte 3, then a full packet afterwards
    drive_cycle(1'b1, rnd10(), rnd10(), rnd10(), rnd10());
    for (int i = 0; i < 30 * CPB + 6; i++) drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);
    check("mid_packet_busy", busy, 1'b1);
    apply_reset(6);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);
    drive_cycle(1'b1, 10'h2AA, 10'h155, 10'h3FF, 10'h001);
    idle_until_ready();
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 10'h0, 10'h0, 10'h0, 10'h0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
